shift_load_register: RTL and testbench

Parameterised parallel-load, bidirectional single-bit shift register used as the working register (accumulator/quotient style) in the ALU datapath. Each bit is built from one 4:1 select cell (`mux_4_to_1`) feeding one enabled flip-flop (`dff`). Per clock it holds, loads, shifts left or shifts right. An optional mode fills two LSBs on a left shift, for SRT-2 style steps.

---
 rtl/shift_load_register_if.sv | 45 ++++
 rtl/shift_load_register.sv | 110 +++++++++++
 tb/tb_shift_load_register.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/shift_load_register_if.sv
// Control/data bundle for shift_load_register. The jump_LSb control is only
// present when SHIFT_JUMP_LSB_EN is defined.
interface shift_load_register_if #(
    parameter int width = 9
);
    logic             i_load_enable;
    logic             i_load;
    logic [width-1:0] i_data_in;
    logic             i_left_shift_enable;
    logic             i_left_shift_value;
    logic             i_right_shift_enable;
    logic             i_right_shift_value;
`ifdef SHIFT_JUMP_LSB_EN
    logic             i_jump_LSb;
`endif
    logic [width-1:0] o_data_out;

    modport master (
        output i_load_enable,
        output i_load,
        output i_data_in,
        output i_left_shift_enable,
        output i_left_shift_value,
        output i_right_shift_enable,
        output i_right_shift_value,
`ifdef SHIFT_JUMP_LSB_EN
        output i_jump_LSb,
`endif
        input  o_data_out
    );

    modport slave (
        input  i_load_enable,
        input  i_load,
        input  i_data_in,
        input  i_left_shift_enable,
        input  i_left_shift_value,
        input  i_right_shift_enable,
        input  i_right_shift_value,
`ifdef SHIFT_JUMP_LSB_EN
        input  i_jump_LSb,
`endif
        output o_data_out
    );
endinterface

// File: rtl/shift_load_register.sv
// Parallel-load, bidirectional single-bit shift register built from per-bit
// 4:1 select cells and enabled flops. Define SHIFT_JUMP_LSB_EN for the two-LSB left-shift fill.
module mux_4_to_1 (
    input  logic [1:0] i_sel,
    input  logic       i_d0,
    input  logic       i_d1,
    input  logic       i_d2,
    input  logic       i_d3,
    output logic       o_y
);
    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'b00:   o_y = i_d0;
            2'b01:   o_y = i_d1;
            2'b10:   o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end
endmodule

module dff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);
    logic r_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_q <= 1'b0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

module shift_load_register #(
    parameter int width = 9
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    shift_load_register_if.slave  bus
);
    logic [width-1:0] w_q;
    logic [1:0]       w_sel;
    logic             w_en;
    logic             w_jump;
    logic             w_unused_load;

    if (width < 3) begin : g_width_check
        $error("shift_load_register: width must be at least 3");
    end

    // Select encoding: 00 hold, 01 load, 10 right shift, 11 left shift.
    assign w_sel[1] = ~bus.i_load_enable & (bus.i_left_shift_enable | bus.i_right_shift_enable);
    assign w_sel[0] = bus.i_load_enable | bus.i_left_shift_enable;
    assign w_en     = bus.i_load_enable | bus.i_left_shift_enable | bus.i_right_shift_enable;

`ifdef SHIFT_JUMP_LSB_EN
    assign w_jump = bus.i_jump_LSb;
`else
    assign w_jump = 1'b0;
`endif

    // The reserved load strobe is accepted but has no effect.
    assign w_unused_load = bus.i_load;

    for (genvar gi = 0; gi < width; gi++) begin : g_bit
        logic w_left_src;
        logic w_right_src;
        logic w_mux_y;

        if (gi == 0) begin : g_left_lsb
            assign w_left_src = bus.i_left_shift_value;
        end else if (gi == 1) begin : g_left_jump
            assign w_left_src = (bus.i_left_shift_value & w_jump) | (w_q[0] & ~w_jump);
        end else begin : g_left_mid
            assign w_left_src = w_q[gi-1];
        end

        if (gi == width - 1) begin : g_right_msb
            assign w_right_src = bus.i_right_shift_value;
        end else begin : g_right_mid
            assign w_right_src = w_q[gi+1];
        end

        mux_4_to_1 u_mux (
            .i_sel (w_sel),
            .i_d0  (w_q[gi]),
            .i_d1  (bus.i_data_in[gi]),
            .i_d2  (w_right_src),
            .i_d3  (w_left_src),
            .o_y   (w_mux_y)
        );

        dff u_dff (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_en    (w_en),
            .i_d     (w_mux_y),
            .o_q     (w_q[gi])
        );
    end

    assign bus.o_data_out = w_q;
endmodule

// File: tb/tb_shift_load_register.sv
// Directed plus randomized bench for shift_load_register (width 8) against an
// arithmetic reference model.
module tb_shift_load_register;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] model;
    int           total;
    int           bad;

    shift_load_register_if #(.width(W)) bus ();

    shift_load_register #(.width(W)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_next(
        input logic [W-1:0] q, input logic le, input logic [W-1:0] d,
        input logic ls, input logic lsv, input logic rs, input logic rsv,
        input logic jmp);
        int unsigned v;
        int unsigned mask;
        mask = (1 << W) - 1;
        v = int'(q);
        if (le)
            v = int'(d);
        else if (ls) begin
            v = ((v * 2) + (lsv ? 1 : 0)) & mask;
            if (jmp)
                v = (v & ~32'd2) | (lsv ? 32'd2 : 32'd0);
        end else if (rs)
            v = (v / 2) + (rsv ? (1 << (W - 1)) : 0);
        return v[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] exp);
        total++;
        assert (bus.o_data_out === exp)
        else begin
            bad++;
            $error("FAIL %s: data_out=0x%h expected=0x%h", tag, bus.o_data_out, exp);
        end
    endtask

    task automatic set_in(input logic le, input logic [W-1:0] d, input logic ls,
                          input logic lsv, input logic rs, input logic rsv,
                          input logic jmp, input logic ld);
        bus.i_load_enable        = le;
        bus.i_data_in            = d;
        bus.i_left_shift_enable  = ls;
        bus.i_left_shift_value   = lsv;
        bus.i_right_shift_enable = rs;
        bus.i_right_shift_value  = rsv;
        bus.i_load               = ld;
`ifdef SHIFT_JUMP_LSB_EN
        bus.i_jump_LSb           = jmp;
`endif
    endtask

    // One clock with the given controls; model tracks the edge, check 1 time unit later.
    task automatic cyc(input string tag, input logic le, input logic [W-1:0] d,
                       input logic ls, input logic lsv, input logic rs, input logic rsv,
                       input logic jmp, input logic ld);
        logic jeff;
`ifdef SHIFT_JUMP_LSB_EN
        jeff = jmp;
`else
        jeff = 1'b0;
`endif
        set_in(le, d, ls, lsv, rs, rsv, jmp, ld);
        @(posedge clk);
        if (reset)
            model = '0;
        else
            model = ref_next(model, le, d, ls, lsv, rs, rsv, jeff);
        #1;
        check(tag, model);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model = '0;
        reset = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_async", 8'h00);
        @(posedge clk); #1;
        check("reset_held", 8'h00);
        cyc("reset_overrides_load", 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        cyc("hold0_a", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("hold0_b", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("hold0_const", 8'h00);

        cyc("load_B2", 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_B2_const", 8'hB2);
        cyc("hold_load_hi", 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("hold_load_lo", 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_B2_const", 8'hB2);

        cyc("shl_0", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("shl_0_const", 8'h64);
        cyc("shl_1", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("shl_1_const", 8'hC9);
        cyc("shr_1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("shr_1_const", 8'hE4);
        cyc("shr_0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("shr_0_const", 8'h72);

        cyc("prio_load", 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("prio_load_const", 8'h0F);
        cyc("prio_left", 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("prio_left_const", 8'h1E);

`ifdef SHIFT_JUMP_LSB_EN
        cyc("jmp_clear_a", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jmp_1", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("jmp_1_const", 8'h03);
        cyc("jmp_clear_b", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jmp_0", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("jmp_0_const", 8'h01);
`endif

        cyc("load_FF", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model = '0;
        check("async_pulse", 8'h00);
        reset = 1'b0;
        cyc("after_pulse_hold", 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_pulse_const", 8'h00);

        for (int i = 0; i < 400; i++) begin
            logic le, ls, rs, lsv, rsv, jmp, ld;
            logic [W-1:0] d;
            le  = ($urandom % 4) == 0;
            ls  = $urandom % 2;
            rs  = $urandom % 2;
            lsv = $urandom % 2;
            rsv = $urandom % 2;
            jmp = $urandom % 2;
            ld  = $urandom % 2;
            d   = W'($urandom);
            if (($urandom % 40) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                model = '0;
                check("rand_async", 8'h00);
                reset = 1'b0;
            end
            cyc("rand", le, d, ls, lsv, rs, rsv, jmp, ld);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
